// File: rtl/vend_pkg.sv
// Shared state encoding, coin-select codes and default denominations
// for the vending-machine change dispenser.
package vend_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StCalc,
    StDispense,
    StDone
  } state_e;

  localparam logic [1:0] SEL_HI  = 2'd0;
  localparam logic [1:0] SEL_MID = 2'd1;
  localparam logic [1:0] SEL_LO  = 2'd2;

  localparam int unsigned COIN_HI_DEF  = 10;
  localparam int unsigned COIN_MID_DEF = 5;
  localparam int unsigned COIN_LO_DEF  = 1;

endpackage

// File: rtl/change_dispenser_if.sv
// Transaction and coin-stream signals of the change dispenser.
// Optional per-denomination counters appear with CHANGE_DISPENSER_COIN_COUNT_EN.
interface change_dispenser_if #(
  parameter int unsigned W = 8
);
  logic         start;
  logic [W-1:0] paid;
  logic [W-1:0] price;
  logic         busy;
  logic [W-1:0] change_amt;
  logic         insufficient;
  logic         coin_valid;
  logic [1:0]   coin_sel;
  logic         coin_ready;
  logic         done;
`ifdef CHANGE_DISPENSER_COIN_COUNT_EN
  logic [W-1:0] cnt_hi;
  logic [W-1:0] cnt_mid;
  logic [W-1:0] cnt_lo;
`endif

  // Dispenser side.
  modport slave (
    input  start, paid, price, coin_ready,
    output busy, change_amt, insufficient, coin_valid, coin_sel, done
`ifdef CHANGE_DISPENSER_COIN_COUNT_EN
    , output cnt_hi, cnt_mid, cnt_lo
`endif
  );

  // Payment accumulator / ejector side.
  modport master (
    output start, paid, price, coin_ready,
    input  busy, change_amt, insufficient, coin_valid, coin_sel, done
`ifdef CHANGE_DISPENSER_COIN_COUNT_EN
    , input cnt_hi, cnt_mid, cnt_lo
`endif
  );

endinterface

// File: rtl/change_sub.sv
// W-bit two's-complement subtractor: diff = a + ~b + 1, borrow = ~carry-out.
module change_sub #(
  parameter int unsigned W = 8
) (
  input  logic [W-1:0] i_a,
  input  logic [W-1:0] i_b,
  output logic [W-1:0] o_diff,
  output logic         o_borrow_out
);

  logic w_carry;

  assign {w_carry, o_diff} = {1'b0, i_a} + {1'b0, ~i_b} + {{W{1'b0}}, 1'b1};
  assign o_borrow_out      = ~w_carry;

endmodule

// File: rtl/change_dispenser.sv
// Change-return engine: subtracts price from paid, then streams greedy coin requests.
// Define CHANGE_DISPENSER_COIN_COUNT_EN to add per-denomination coin counters.
module change_dispenser
  import vend_pkg::*;
#(
  parameter int unsigned W        = 8,
  parameter int unsigned COIN_HI  = COIN_HI_DEF,
  parameter int unsigned COIN_MID = COIN_MID_DEF,
  parameter int unsigned COIN_LO  = COIN_LO_DEF
) (
  input logic               clk,
  input logic               rst_n,
  change_dispenser_if.slave io_bus
);

  if (COIN_LO != 1) begin : g_chk_lo
    $fatal(1, "COIN_LO must be 1");
  end
  if (!(COIN_HI > COIN_MID && COIN_MID > COIN_LO)) begin : g_chk_order
    $fatal(1, "denominations must satisfy COIN_HI > COIN_MID > COIN_LO");
  end
  if ((W < 32) && (COIN_HI >= (32'd1 << W))) begin : g_chk_range
    $fatal(1, "denominations must fit in W bits");
  end

  localparam logic [W-1:0] CoinHi  = W'(COIN_HI);
  localparam logic [W-1:0] CoinMid = W'(COIN_MID);
  localparam logic [W-1:0] CoinLo  = W'(COIN_LO);

  state_e       r_state;
  logic [W-1:0] r_paid, r_price, r_rem, r_change_amt;
  logic         r_busy, r_insufficient, r_coin_valid, r_done;

  logic [W-1:0] w_diff, w_coin_val, w_rem_next;
  logic         w_borrow, w_fire;
  logic [1:0]   w_sel;

  change_sub #(
    .W(W)
  ) u_sub (
    .i_a          (r_paid),
    .i_b          (r_price),
    .o_diff       (w_diff),
    .o_borrow_out (w_borrow)
  );

  // Greedy pick from the registered remainder, so the choice holds through a stall.
  always_comb begin
    w_sel      = SEL_HI;
    w_coin_val = CoinHi;
    if (r_rem >= CoinHi) begin
      w_sel      = SEL_HI;
      w_coin_val = CoinHi;
    end else if (r_rem >= CoinMid) begin
      w_sel      = SEL_MID;
      w_coin_val = CoinMid;
    end else begin
      w_sel      = SEL_LO;
      w_coin_val = CoinLo;
    end
  end

  assign w_fire     = r_coin_valid & io_bus.coin_ready;
  assign w_rem_next = r_rem - w_coin_val;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state        <= StIdle;
      r_paid         <= '0;
      r_price        <= '0;
      r_rem          <= '0;
      r_change_amt   <= '0;
      r_busy         <= 1'b0;
      r_insufficient <= 1'b0;
      r_coin_valid   <= 1'b0;
      r_done         <= 1'b0;
    end else begin
      r_insufficient <= 1'b0;
      r_done         <= 1'b0;
      unique case (r_state)
        StIdle: begin
          if (io_bus.start) begin
            r_paid  <= io_bus.paid;
            r_price <= io_bus.price;
            r_busy  <= 1'b1;
            r_state <= StCalc;
          end
        end
        StCalc: begin
          if (w_borrow) begin
            r_change_amt   <= '0;
            r_insufficient <= 1'b1;
            r_done         <= 1'b1;
            r_busy         <= 1'b0;
            r_state        <= StIdle;
          end else if (w_diff == '0) begin
            r_change_amt <= '0;
            r_state      <= StDone;
          end else begin
            r_change_amt <= w_diff;
            r_rem        <= w_diff;
            r_coin_valid <= 1'b1;
            r_state      <= StDispense;
          end
        end
        StDispense: begin
          if (w_fire) begin
            r_rem <= w_rem_next;
            if (w_rem_next == '0) begin
              r_coin_valid <= 1'b0;
              r_done       <= 1'b1;
              r_state      <= StDone;
            end
          end
        end
        StDone: begin
          // The dispense path raised done on its final handshake; the exact-payment
          // path raises it here, so done is always a single-cycle pulse.
          r_done  <= ~r_done;
          r_busy  <= 1'b0;
          r_state <= StIdle;
        end
        default: r_state <= StIdle;
      endcase
    end
  end

`ifdef CHANGE_DISPENSER_COIN_COUNT_EN
  logic [W-1:0] r_cnt_hi, r_cnt_mid, r_cnt_lo;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt_hi  <= '0;
      r_cnt_mid <= '0;
      r_cnt_lo  <= '0;
    end else if ((r_state == StIdle) && io_bus.start) begin
      r_cnt_hi  <= '0;
      r_cnt_mid <= '0;
      r_cnt_lo  <= '0;
    end else if (w_fire) begin
      unique case (w_sel)
        SEL_HI:  r_cnt_hi  <= r_cnt_hi + 1'b1;
        SEL_MID: r_cnt_mid <= r_cnt_mid + 1'b1;
        SEL_LO:  r_cnt_lo  <= r_cnt_lo + 1'b1;
        default: ;
      endcase
    end
  end

  assign io_bus.cnt_hi  = r_cnt_hi;
  assign io_bus.cnt_mid = r_cnt_mid;
  assign io_bus.cnt_lo  = r_cnt_lo;
`endif

  assign io_bus.busy         = r_busy;
  assign io_bus.change_amt   = r_change_amt;
  assign io_bus.insufficient = r_insufficient;
  assign io_bus.coin_valid   = r_coin_valid;
  assign io_bus.coin_sel     = r_coin_valid ? w_sel : SEL_HI;
  assign io_bus.done         = r_done;

endmodule
